// File: rtl/mult_pipe_fu.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with valid/ready at both ends.
// Each stage folds CH multiplier bits into a 2*XLEN accumulator; the last stage applies the sign fix-up.
module mult_pipe_fu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned ROB_W      = 5,
  localparam int unsigned OCC_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [1:0]       in_func,
  input  logic [TAG_W-1:0] in_dest_tag,
  input  logic [ROB_W-1:0] in_rob_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_dest_tag,
  output logic [ROB_W-1:0] out_rob_idx,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned CH   = XLEN / NUM_STAGES;
  localparam int unsigned W2   = 2 * XLEN;
  localparam int unsigned LAST = NUM_STAGES - 1;
  localparam int unsigned OPN  = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  typedef enum logic [1:0] {
    FN_MUL    = 2'b00,
    FN_MULH   = 2'b01,
    FN_MULHSU = 2'b10,
    FN_MULHU  = 2'b11
  } func_e;

  if (XLEN % NUM_STAGES != 0) begin : g_bad_cfg
    $error("mult_pipe_fu: XLEN must be a multiple of NUM_STAGES");
  end

  // Per-stage registers
  logic [NUM_STAGES-1:0] valid_q;
  logic [OCC_W-1:0]      occ_q;
  logic [W2-1:0]         acc_q  [NUM_STAGES];
  func_e                 func_q [NUM_STAGES];
  logic [TAG_W-1:0]      tag_q  [NUM_STAGES];
  logic [ROB_W-1:0]      rob_q  [NUM_STAGES];
  // Operands are only needed by stages that still have work downstream
  logic [W2-1:0]         a_q    [OPN];
  logic [XLEN-1:0]       b_q    [OPN];
  logic                  bneg_q [OPN];

  // Values presented to each stage's input
  logic [W2-1:0]         src_a    [NUM_STAGES];
  logic [XLEN-1:0]       src_b    [NUM_STAGES];
  logic                  src_bneg [NUM_STAGES];
  logic [W2-1:0]         src_acc  [NUM_STAGES];
  func_e                 src_func [NUM_STAGES];
  logic [TAG_W-1:0]      src_tag  [NUM_STAGES];
  logic [ROB_W-1:0]      src_rob  [NUM_STAGES];
  logic [W2-1:0]         acc_n    [NUM_STAGES];

  logic [NUM_STAGES-1:0] load;
  logic [NUM_STAGES-1:0] valid_n;
  logic [OCC_W-1:0]      occ_n;

  func_e                 func_in;
  logic                  signed_a;
  logic [W2-1:0]         a_ext_in;
  logic                  bneg_in;

  assign func_in  = func_e'(in_func);
  assign signed_a = (func_in == FN_MULH) || (func_in == FN_MULHSU);
  assign a_ext_in = {{XLEN{signed_a & in_opa[XLEN-1]}}, in_opa};
  // A sign-extended opb equals opb + sign*(2^W2 - 2^XLEN); the second term becomes the fix-up
  assign bneg_in  = (func_in == FN_MULH) & in_opb[XLEN-1];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [CH-1:0] chunk;
    logic [W2-1:0] pp;
    logic [W2-1:0] corr;

    if (k == 0) begin : g_src_in
      assign src_a[k]    = a_ext_in;
      assign src_b[k]    = in_opb;
      assign src_bneg[k] = bneg_in;
      assign src_acc[k]  = '0;
      assign src_func[k] = func_in;
      assign src_tag[k]  = in_dest_tag;
      assign src_rob[k]  = in_rob_idx;
    end else begin : g_src_q
      assign src_a[k]    = a_q[k-1];
      assign src_b[k]    = b_q[k-1];
      assign src_bneg[k] = bneg_q[k-1];
      assign src_acc[k]  = acc_q[k-1];
      assign src_func[k] = func_q[k-1];
      assign src_tag[k]  = tag_q[k-1];
      assign src_rob[k]  = rob_q[k-1];
    end

    assign chunk = src_b[k][k*CH +: CH];
    assign pp    = src_a[k] * {{(W2-CH){1'b0}}, chunk};

    if (k == LAST) begin : g_fix
      assign corr = src_bneg[k] ? ({W2{1'b0}} - (src_a[k] << XLEN)) : '0;
    end else begin : g_nofix
      assign corr = '0;
    end

    assign acc_n[k] = src_acc[k] + (pp << (k*CH)) + corr;
  end

  // load[s]: stage s takes new content this cycle (it is empty or its content moves on)
  always_comb begin
    load    = '0;
    valid_n = valid_q;
    occ_n   = '0;
    load[LAST] = !valid_q[LAST] || out_ready;
    for (int unsigned s = LAST; s > 0; s--) begin
      load[s-1] = !valid_q[s-1] || load[s];
    end
    if (flush) begin
      valid_n = '0;
    end else begin
      if (load[0]) valid_n[0] = in_valid;
      for (int unsigned s = 1; s < NUM_STAGES; s++) begin
        if (load[s]) valid_n[s] = valid_q[s-1];
      end
    end
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      occ_n = occ_n + OCC_W'(valid_n[s]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        acc_q[s]  <= '0;
        func_q[s] <= FN_MUL;
        tag_q[s]  <= '0;
        rob_q[s]  <= '0;
      end
      for (int unsigned s = 0; s < OPN; s++) begin
        a_q[s]    <= '0;
        b_q[s]    <= '0;
        bneg_q[s] <= 1'b0;
      end
    end else begin
      valid_q <= valid_n;
      occ_q   <= occ_n;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        if (load[s]) begin
          acc_q[s]  <= acc_n[s];
          func_q[s] <= src_func[s];
          tag_q[s]  <= src_tag[s];
          rob_q[s]  <= src_rob[s];
        end
      end
      for (int unsigned s = 0; s < LAST; s++) begin
        if (load[s]) begin
          a_q[s]    <= src_a[s];
          b_q[s]    <= src_b[s];
          bneg_q[s] <= src_bneg[s];
        end
      end
    end
  end

  assign in_ready     = load[0];
  assign out_valid    = valid_q[LAST];
  assign out_result   = (func_q[LAST] == FN_MUL) ? acc_q[LAST][XLEN-1:0] : acc_q[LAST][W2-1:XLEN];
  assign out_dest_tag = tag_q[LAST];
  assign out_rob_idx  = rob_q[LAST];
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_mult_pipe_fu.sv
// Self-checking bench for mult_pipe_fu: scoreboard of expected results plus per-scenario tasks.
module tb_mult_pipe_fu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opa = '0;
  logic [31:0] in_opb = '0;
  logic [1:0]  in_func = '0;
  logic [5:0]  in_dest_tag = '0;
  logic [4:0]  in_rob_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [5:0]  out_dest_tag;
  logic [4:0]  out_rob_idx;
  logic [2:0]  occupancy;

  mult_pipe_fu #(.XLEN(32), .NUM_STAGES(4), .TAG_W(6), .ROB_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func),
    .in_dest_tag(in_dest_tag), .in_rob_idx(in_rob_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest_tag(out_dest_tag), .out_rob_idx(out_rob_idx), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [4:0]  rob;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (f == 2'b01 || f == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (f == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: every consumed result must match the oldest accepted op
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got tag %0h result %h, required no output", out_dest_tag, out_result);
      end else begin
        mon_e = sb.pop_front();
        if ({out_result, out_dest_tag, out_rob_idx} !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard: got res %h tag %0h rob %0h, required res %h tag %0h rob %0h",
                   out_result, out_dest_tag, out_rob_idx, mon_e.res, mon_e.tag, mon_e.rob);
        end
      end
    end
  end

  // One clock of stimulus; returns 1 ns after the edge
  task automatic drive_cycle(input logic v, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] tag, input logic [4:0] rob, input logic ordy, input logic fl,
                             output logic acc);
    exp_t e;
    in_valid = v; in_func = f; in_opa = a; in_opb = b;
    in_dest_tag = tag; in_rob_idx = rob; out_ready = ordy; flush = fl;
    @(negedge clock);
    acc = v && in_ready && !fl;
    if (acc) begin
      e.res = model(f, a, b); e.tag = tag; e.rob = rob;
      sb.push_back(e);
    end
    @(posedge clock);
    if (fl) sb.delete();
    #1;
    n_checks++;
    if (int'(occupancy) !== sb.size()) begin
      n_fail++;
      $display("FAIL occupancy: got %0d, required %0d", occupancy, sb.size());
    end
  endtask

  task automatic idle(input logic ordy);
    logic dummy;
    drive_cycle(1'b0, 2'b00, '0, '0, '0, '0, ordy, 1'b0, dummy);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({out_valid, in_ready, occupancy} !== 5'b0_1_000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got out_valid %b in_ready %b occ %0d, required 0 1 0", out_valid, in_ready, occupancy);
    end
    n_checks++;
    if ({out_result, out_dest_tag, out_rob_idx} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h, required zeros", out_result, out_dest_tag, out_rob_idx);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_mul;
    logic acc;
    int   lat;
    drive_cycle(1'b1, 2'b00, 32'd3, 32'hFFFF_FFFE, 6'h15, 5'h0A, 1'b1, 1'b0, acc);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL mul_accept: got %b, required 1", acc); end
    lat = 1;
    while (!out_valid && lat < 12) begin idle(1'b1); lat++; end
    n_checks++;
    if (!out_valid || lat != 4) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d cycles (valid %b), required 4", lat, out_valid);
    end
    n_checks++;
    if ({out_result, out_dest_tag, out_rob_idx} !== {32'hFFFF_FFFA, 6'h15, 5'h0A}) begin
      n_fail++;
      $display("FAIL mul_result: got %h tag %0h rob %0h, required fffffffa 15 a", out_result, out_dest_tag, out_rob_idx);
    end
    idle(1'b1);
  endtask

  task automatic test_high;
    logic        acc;
    logic [1:0]  fns  [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] opa  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] opb  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] hexp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int          k = 0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, fns[i], opa[i], opb[i], 6'(i + 1), 5'(i + 1), 1'b1, 1'b0, acc);
    for (int c = 0; c < 12; c++) begin
      if (out_valid && k < 3) begin
        n_checks++;
        if (out_result !== hexp[k]) begin
          n_fail++;
          $display("FAIL high_result[%0d]: got %h, required %h", k, out_result, hexp[k]);
        end
        k++;
      end
      idle(1'b1);
    end
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL high_count: got %0d results, required 3", k); end
  endtask

  task automatic test_back_to_back;
    logic acc;
    int   accepted = 0, run = 0, max_run = 0, total = 0, max_occ = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        drive_cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 6'(8 + c), 5'(c), 1'b1, 1'b0, acc);
        if (acc) accepted++;
      end else begin
        idle(1'b1);
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (out_valid) begin run++; total++; if (run > max_run) max_run = run; end
      else run = 0;
    end
    n_checks++;
    if (accepted != 8 || total != 8 || max_run != 8) begin
      n_fail++;
      $display("FAIL b2b_stream: got accepted %0d total %0d run %0d, required 8 8 8", accepted, total, max_run);
    end
    n_checks++;
    if (max_occ != 4) begin n_fail++; $display("FAIL b2b_occ_peak: got %0d, required 4", max_occ); end
  endtask

  task automatic test_backpressure;
    logic        acc;
    int          accepted = 0;
    logic [42:0] held;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 2'(i), 32'h1357_0000 + 32'(i), 32'hF00D_0000 - 32'(i), 6'(20 + i), 5'(20 + i), 1'b0, 1'b0, acc);
      if (acc) accepted++;
    end
    n_checks++;
    if (accepted != 4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: got accepted %0d in_ready %b, required 4 0", accepted, in_ready);
    end
    held = {out_result, out_dest_tag, out_rob_idx};
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      n_checks++;
      if (!out_valid || {out_result, out_dest_tag, out_rob_idx} !== held) begin
        n_fail++;
        $display("FAIL bp_stable: got valid %b data %h, required 1 %h", out_valid,
                 {out_result, out_dest_tag, out_rob_idx}, held);
      end
    end
    drive_cycle(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 6'h3F, 5'h1F, 1'b1, 1'b0, acc);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_full_passthru: got accept %b, required 1", acc); end
    repeat (8) idle(1'b1);
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pending valid %b, required 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_flush;
    logic acc;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b00, 32'(i + 5), 32'(i + 7), 6'(48 + i), 5'(i), 1'b1, 1'b0, acc);
    drive_cycle(1'b1, 2'b01, 32'h1234, 32'h5678, 6'h33, 5'h3, 1'b1, 1'b1, acc);
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: got valid %b occ %0d in_ready %b, required 0 0 1", out_valid, occupancy, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak: got out_valid 1 tag %0h, required 0", out_dest_tag);
      end
    end
  endtask

  task automatic test_async_reset;
    logic acc;
    int   lat;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 2'b10, 32'hFFFF_0000 + 32'(i), 32'(i + 3), 6'(40 + i), 5'(i), 1'b0, 1'b0, acc);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got out_valid %b, required 1", out_valid); end
    #2 reset = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_now: got valid %b occ %0d in_ready %b, required 0 0 1", out_valid, occupancy, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    drive_cycle(1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 6'h2A, 5'h15, 1'b1, 1'b0, acc);
    lat = 1;
    while (!out_valid && lat < 12) begin idle(1'b1); lat++; end
    n_checks++;
    if (!out_valid || lat != 4 || out_result !== model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0) || out_dest_tag !== 6'h2A) begin
      n_fail++;
      $display("FAIL areset_after: got lat %0d valid %b res %h tag %0h, required 4 1 %h 2a",
               lat, out_valid, out_result, model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0), out_dest_tag);
    end
    idle(1'b1);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_pending: got %0d, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_high();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
